// File: rtl/serial_add_sub_ctrl_pkg.sv
// Shared types for the bit-serial add/subtract engine.
// Holds the FSM state encoding and the counter width helper.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter width: $clog2(WIDTH), never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_sub_ctrl_fa.sv
// Single-bit full adder: the only arithmetic resource of the serial engine.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of one bit position.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/serial_add_sub_ctrl.sv
// Bit-serial add/subtract engine: one full adder, one bit per cycle, LSB first.
// Optional macro SAS_OVF_EN adds the o_ovf port (signed overflow of the last op).
//
// Handshake: a request is taken on a rising edge where i_start=1 and the FSM
// is in IDLE. That includes the cycle in which o_done is high, so a host can
// issue back-to-back ops every WIDTH+2 cycles. o_busy is high from the cycle
// after accept through the o_done cycle inclusive. Requests arriving while
// an op is in flight are dropped, not queued.
module serial_add_sub_ctrl
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
`ifdef SAS_OVF_EN
  output logic             o_ovf,
`endif
  output logic             o_cout
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;

  fa u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Control FSM, operand shifters and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
      o_cout   <= 1'b0;
`ifdef SAS_OVF_EN
      o_ovf    <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            a_sh   <= i_a;
            b_sh   <= i_b ^ {WIDTH{i_sub}};
            carry  <= i_sub;
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= RUN;
          end else begin
            o_busy <= 1'b0;
          end
        end
        RUN: begin
          o_result <= {fa_s, o_result[WIDTH-1:1]};
          a_sh     <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh     <= {1'b0, b_sh[WIDTH-1:1]};
          carry    <= fa_co;
          cnt      <= cnt + CW'(1);
          if (cnt == LAST) begin
`ifdef SAS_OVF_EN
            // Carry into the MSB differs from carry out of it.
            o_ovf <= carry ^ fa_co;
`endif
            state <= DONE;
          end
        end
        DONE: begin
          o_done <= 1'b1;
          o_cout <= carry;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// Directed bench for serial_add_sub_ctrl (WIDTH=4).
// Build with +define+SAS_OVF_EN to also check o_ovf.
module tb_serial_add_sub_ctrl;

  localparam int WIDTH = 4;
  localparam int LAT   = WIDTH + 1;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic             i_sub = 1'b0;
  logic [WIDTH-1:0] i_a = '0;
  logic [WIDTH-1:0] i_b = '0;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic             o_cout;
`ifdef SAS_OVF_EN
  logic             o_ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_add_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (i_start),
    .i_sub    (i_sub),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result),
`ifdef SAS_OVF_EN
    .o_ovf    (o_ovf),
`endif
    .o_cout   (o_cout)
  );

  // Clock: 10 time-unit period.
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request for exactly one accept edge; return #1 after it.
  task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                        input string tag);
    i_a     = a;
    i_b     = b;
    i_sub   = sub;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    chk({tag, "_busy_acc"}, 32'(o_busy), 32'd1);
  endtask

  // Wait (bounded) for o_done; checks busy each cycle and the latency.
  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge i_clk);
      #1;
      chk({tag, "_busy_run"}, 32'(o_busy), 32'd1);
      if (o_done) begin
        cyc = k;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(LAT));
  endtask

  task automatic check_res(input string tag, input logic [WIDTH-1:0] r, input logic c,
                           input logic ovf);
    chk({tag, "_result"}, 32'(o_result), 32'(r));
    chk({tag, "_cout"}, 32'(o_cout), 32'(c));
`ifdef SAS_OVF_EN
    chk({tag, "_ovf"}, 32'(o_ovf), 32'(ovf));
`else
    if (ovf === 1'bx) chk({tag, "_ovf_x"}, 32'(ovf), 32'd0);
`endif
  endtask

  // One idle cycle after o_done: done drops, busy drops.
  task automatic check_idle(input string tag);
    @(posedge i_clk);
    #1;
    chk({tag, "_done_low"}, 32'(o_done), 32'd0);
    chk({tag, "_busy_low"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_result", 32'(o_result), 32'd0);
    chk("rst_cout", 32'(o_cout), 32'd0);
`ifdef SAS_OVF_EN
    chk("rst_ovf", 32'(o_ovf), 32'd0);
`endif
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // 3+5 = 8: signed overflow, no carry
    accept(4'd3, 4'd5, 1'b0, "add3_5");
    wait_done("add3_5");
    check_res("add3_5", 4'b1000, 1'b0, 1'b1);
    check_idle("add3_5");

    // 9+9 then back-to-back 15+1 accepted in the o_done cycle
    accept(4'd9, 4'd9, 1'b0, "add9_9");
    wait_done("add9_9");
    check_res("add9_9", 4'b0010, 1'b1, 1'b1);
    accept(4'd15, 4'd1, 1'b0, "add15_1");
    chk("b2b_hold_result", 32'(o_result), 32'd2);
    chk("b2b_done_low", 32'(o_done), 32'd0);
    wait_done("add15_1");
    check_res("add15_1", 4'd0, 1'b1, 1'b0);
    check_idle("add15_1");

    // Subtractions
    accept(4'd5, 4'd3, 1'b1, "sub5_3");
    wait_done("sub5_3");
    check_res("sub5_3", 4'd2, 1'b1, 1'b0);
    check_idle("sub5_3");

    accept(4'd3, 4'd5, 1'b1, "sub3_5");
    wait_done("sub3_5");
    check_res("sub3_5", 4'b1110, 1'b0, 1'b0);
    check_idle("sub3_5");

    accept(4'd8, 4'd1, 1'b1, "sub8_1");
    wait_done("sub8_1");
    check_res("sub8_1", 4'd7, 1'b1, 1'b1);
    check_idle("sub8_1");

    // Start held high with changing operands during an op: ignored
    accept(4'd3, 4'd5, 1'b0, "ign");
    begin
      int cyc;
      cyc = 0;
      for (int k = 1; k <= 20; k++) begin
        i_start = 1'b1;
        i_a     = 4'(k);
        i_b     = 4'(15 - k);
        i_sub   = k[0];
        @(posedge i_clk);
        #1;
        if (o_done) begin
          cyc = k;
          break;
        end
      end
      i_start = 1'b0;
      chk("ign_latency", 32'(cyc), 32'(LAT));
    end
    check_res("ign", 4'b1000, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) check_idle("ign_after");

    // Async reset in the second RUN cycle
    accept(4'd5, 4'd3, 1'b1, "rst_mid");
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(o_busy), 32'd0);
    chk("rstmid_done", 32'(o_done), 32'd0);
    chk("rstmid_result", 32'(o_result), 32'd0);
    chk("rstmid_cout", 32'(o_cout), 32'd0);
`ifdef SAS_OVF_EN
    chk("rstmid_ovf", 32'(o_ovf), 32'd0);
`endif
    repeat (3) begin
      @(posedge i_clk);
      #1;
      chk("rstmid_no_done", 32'(o_done), 32'd0);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      @(posedge i_clk);
      #1;
      chk("rstmid_no_late_done", 32'(o_done), 32'd0);
    end
    accept(4'd5, 4'd3, 1'b1, "after_rst");
    wait_done("after_rst");
    check_res("after_rst", 4'd2, 1'b1, 1'b0);
    check_idle("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
